johnson_phase_monitor: RTL and testbench
========================================

JOHNSON_PHASE_MONITOR -- requirements
Module: johnson_phase_monitor

Interface
REQ-001 The block SHALL have parameter LOCK_LEN, default 8, setting the number of consecutive legal Johnson transitions required to declare lock (range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the rising-edge clock for all sequential logic.
REQ-003 The block SHALL have port reset, input, 1, an asynchronous, active-high reset.
REQ-004 The block SHALL have port jc_q, input, 4, the state of the upstream 4-bit right-shift Johnson counter.
REQ-005 The block SHALL have port in_valid, input, 1, which marks jc_q as a new sample; in_valid is asserted only when the counter has advanced.
REQ-006 The block SHALL have port clr_cnt, input, 1, a synchronous clear of err_cnt and cycle_cnt.
REQ-007 The block SHALL have port phase_onehot, output, 8, the one-hot decode of the last sample.
REQ-008 The block SHALL have port phase_idx, output, 3, the binary phase index of the last sample.
REQ-009 The block SHALL have port legal, output, 1, which is 1 when the last sample was one of the 8 legal codes.
REQ-010 The block SHALL have port locked, output, 1, which is 1 when the FSM is in LOCKED.
REQ-011 The block SHALL have port seq_err, output, 1, a one-cycle error pulse.
REQ-012 The block SHALL have port cycle_done, output, 1, a one-cycle pulse on each completed lap.
REQ-013 The block SHALL have port err_cnt, output, 8, a saturating error count.
REQ-014 The block SHALL have port cycle_cnt, output, 16, a wrapping lap count.

Function
REQ-015 The block SHALL map legal codes to phases as follows: 0000->0, 1000->1, 1100->2, 1110->3, 1111->4, 0111->5, 0011->6, 0001->7; all 8 other codes SHALL be illegal.
REQ-016 The block SHALL define the successor of a code p as {~p[0], p[3:1]}, and seq_ok SHALL mean jc_q equals the successor of the stored prev_q.
REQ-017 All outputs SHALL be registered and SHALL update on the clock edge that samples in_valid=1, giving one cycle of latency; with in_valid=0, all outputs SHALL hold, except that pulses SHALL return to 0.
REQ-018 On a legal sample, phase_onehot SHALL equal 1<<phase, phase_idx SHALL equal the phase, and legal SHALL be 1; on an illegal sample, phase_onehot SHALL be 0, phase_idx SHALL be 0, and legal SHALL be 0.
REQ-019 On every in_valid sample, prev_q SHALL load jc_q.
REQ-020 The FSM SHALL have the states IDLE, TRACK and LOCKED, with a run counter run_cnt of 4 bits.
REQ-021 In IDLE, a legal sample SHALL move the FSM to TRACK with run_cnt=0, and an illegal sample SHALL keep it in IDLE.
REQ-022 In TRACK, a seq_ok sample SHALL increment run_cnt, and when run_cnt+1 == LOCK_LEN the FSM SHALL move to LOCKED.
REQ-023 In TRACK, a legal sample without seq_ok SHALL resynchronise by setting run_cnt=0 and staying in TRACK, and an illegal sample SHALL move the FSM to IDLE.
REQ-024 In LOCKED, a seq_ok sample SHALL keep the FSM in LOCKED, a legal sample without seq_ok SHALL move it to TRACK with run_cnt=0, and an illegal sample SHALL move it to IDLE.
REQ-025 seq_err SHALL pulse on any in_valid sample that is illegal, or that is legal but not seq_ok while the FSM is in TRACK or LOCKED; the first legal sample taken in IDLE SHALL NOT be an error.
REQ-026 cycle_done SHALL pulse on a seq_ok sample in LOCKED with jc_q=0000, which is the 0001->0000 wrap.
REQ-027 err_cnt SHALL increment on each seq_err and SHALL saturate at 255.
REQ-028 cycle_cnt SHALL increment on each cycle_done and SHALL wrap from 65535 to 0.
REQ-029 When clr_cnt is asserted, err_cnt and cycle_cnt SHALL be 0 the next cycle, and clr_cnt SHALL win over a simultaneous increment; the pulses themselves SHALL still be generated.
REQ-030 A repeated identical sample (jc_q == prev_q) SHALL be treated as legal-but-not-seq_ok.

Reset
REQ-031 While reset=1, the FSM SHALL be in IDLE and run_cnt and prev_q SHALL be 0.
REQ-032 While reset=1, every output SHALL be 0, including phase_onehot=00000000 and the counts.
REQ-033 Reset SHALL take effect immediately, without a clock edge, including mid-LOCKED.
REQ-034 After reset release, the first in_valid sample SHALL be handled as an IDLE entry.

Verification
REQ-035 Lock acquisition: after reset, drive 0000,1000,1100,... with in_valid=1 every cycle -> phase_onehot shall step 01,02,04,...; locked shall be 1 one cycle after the 9th sample; seq_err shall stay 0.
REQ-036 Illegal code: while locked, drive 0101 -> next cycle seq_err=1 for 1 cycle, legal=0, phase_onehot=0, locked=0, err_cnt=1; then 0000 -> TRACK, with no error.
REQ-037 Skipped state: while locked, drive 0000 then 1100 -> seq_err=1 and locked=0; after 8 more consecutive legal steps, locked=1 again.
REQ-038 Lap counting: while locked, run 3 full laps -> cycle_done shall pulse 3 times, each on 0001->0000, and cycle_cnt=3.
REQ-039 Counter limits: 300 illegal samples -> err_cnt=255 and held there; clr_cnt coincident with a seq_err -> err_cnt=0, and the seq_err pulse shall still be seen.
REQ-040 Asynchronous reset: assert reset between clock edges while locked, with clk gated -> all outputs shall be 0 immediately; after release, the first legal sample shall give seq_err=0.

Source files
------------

// File: rtl/johnson_phase_monitor.sv
// Johnson counter phase monitor: decodes a 4-bit Johnson state,
// tracks sequence lock and counts sequence errors and laps.
module johnson_phase_monitor #(
  parameter int LOCK_LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  jc_q,
  input  logic        in_valid,
  input  logic        clr_cnt,
  output logic [7:0]  phase_onehot,
  output logic [2:0]  phase_idx,
  output logic        legal,
  output logic        locked,
  output logic        seq_err,
  output logic        cycle_done,
  output logic [7:0]  err_cnt,
  output logic [15:0] cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED
  } state_t;

  localparam logic [4:0] LOCK_W = 5'(LOCK_LEN);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] run_cnt;
  logic [3:0] run_nxt;
  logic [4:0] run_inc;
  logic [3:0] prev_q;
  logic       dec_legal;
  logic [2:0] dec_idx;
  logic       seq_ok;
  logic       err_d;
  logic       done_d;

  always_comb begin
    dec_legal = 1'b1;
    dec_idx   = 3'd0;
    unique case (jc_q)
      4'b0000: dec_idx = 3'd0;
      4'b1000: dec_idx = 3'd1;
      4'b1100: dec_idx = 3'd2;
      4'b1110: dec_idx = 3'd3;
      4'b1111: dec_idx = 3'd4;
      4'b0111: dec_idx = 3'd5;
      4'b0011: dec_idx = 3'd6;
      4'b0001: dec_idx = 3'd7;
      default: dec_legal = 1'b0;
    endcase
  end

  assign seq_ok  = (jc_q == {~prev_q[0], prev_q[3:1]});
  assign run_inc = {1'b0, run_cnt} + 5'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      run_cnt <= 4'd0;
    end else if (in_valid) begin
      state   <= state_nxt;
      run_cnt <= run_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    if (!dec_legal) begin
      state_nxt = IDLE;
      run_nxt   = 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = TRACK;
          run_nxt   = 4'd0;
        end
        TRACK: begin
          if (seq_ok) begin
            run_nxt = run_inc[3:0];
            if (run_inc == LOCK_W)
              state_nxt = LOCKED;
          end else begin
            run_nxt = 4'd0;
          end
        end
        LOCKED: begin
          if (!seq_ok) begin
            state_nxt = TRACK;
            run_nxt   = 4'd0;
          end
        end
        default: begin
          state_nxt = IDLE;
          run_nxt   = 4'd0;
        end
      endcase
    end
  end

  // First legal code in IDLE only seeds the tracker, it is never an error.
  always_comb begin
    err_d  = !dec_legal || ((state != IDLE) && !seq_ok);
    done_d = (state == LOCKED) && seq_ok && (jc_q == 4'b0000);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_onehot <= 8'd0;
      phase_idx    <= 3'd0;
      legal        <= 1'b0;
      locked       <= 1'b0;
      seq_err      <= 1'b0;
      cycle_done   <= 1'b0;
      prev_q       <= 4'd0;
      err_cnt      <= 8'd0;
      cycle_cnt    <= 16'd0;
    end else begin
      seq_err    <= 1'b0;
      cycle_done <= 1'b0;
      if (in_valid) begin
        phase_onehot <= dec_legal ? (8'd1 << dec_idx) : 8'd0;
        phase_idx    <= dec_idx;
        legal        <= dec_legal;
        locked       <= (state_nxt == LOCKED);
        seq_err      <= err_d;
        cycle_done   <= done_d;
        prev_q       <= jc_q;
      end
      if (clr_cnt) begin
        err_cnt   <= 8'd0;
        cycle_cnt <= 16'd0;
      end else begin
        if (in_valid && err_d && (err_cnt != 8'hff))
          err_cnt <= err_cnt + 8'd1;
        if (in_valid && done_d)
          cycle_cnt <= cycle_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Bench for johnson_phase_monitor: directed scenarios plus
// random traffic against a phase-arithmetic reference model.
module tb_johnson_phase_monitor;

  localparam int LOCK_LEN = 8;

  logic        clk;
  logic        clk_en;
  logic        reset;
  logic [3:0]  jc_q;
  logic        in_valid;
  logic        clr_cnt;
  logic [7:0]  phase_onehot;
  logic [2:0]  phase_idx;
  logic        legal;
  logic        locked;
  logic        seq_err;
  logic        cycle_done;
  logic [7:0]  err_cnt;
  logic [15:0] cycle_cnt;

  int n_cmp;
  int n_bad;

  // reference model state
  int         m_state;
  int         m_run;
  logic [3:0] m_prev;
  logic [7:0] e_oh;
  logic [2:0] e_idx;
  logic       e_legal;
  logic       e_locked;
  logic       e_err;
  logic       e_done;
  int         e_errcnt;
  int         e_cyc;

  johnson_phase_monitor #(.LOCK_LEN(LOCK_LEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .jc_q         (jc_q),
    .in_valid     (in_valid),
    .clr_cnt      (clr_cnt),
    .phase_onehot (phase_onehot),
    .phase_idx    (phase_idx),
    .legal        (legal),
    .locked       (locked),
    .seq_err      (seq_err),
    .cycle_done   (cycle_done),
    .err_cnt      (err_cnt),
    .cycle_cnt    (cycle_cnt)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  function automatic logic [3:0] code_of(input int k);
    case (k % 8)
      0: return 4'b0000;
      1: return 4'b1000;
      2: return 4'b1100;
      3: return 4'b1110;
      4: return 4'b1111;
      5: return 4'b0111;
      6: return 4'b0011;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic int ph(input logic [3:0] c);
    for (int k = 0; k < 8; k++)
      if (code_of(k) == c) return k;
    return -1;
  endfunction

  function automatic void model_reset();
    m_state  = 0;
    m_run    = 0;
    m_prev   = 4'b0000;
    e_oh     = 8'd0;
    e_idx    = 3'd0;
    e_legal  = 1'b0;
    e_locked = 1'b0;
    e_err    = 1'b0;
    e_done   = 1'b0;
    e_errcnt = 0;
    e_cyc    = 0;
  endfunction

  // states: 0 idle, 1 tracking, 2 locked
  function automatic void model_step(input logic v, input logic [3:0] c,
                                     input logic clr);
    int p;
    int pp;
    bit ok;
    e_err  = 1'b0;
    e_done = 1'b0;
    if (v) begin
      p  = ph(c);
      pp = ph(m_prev);
      ok = (p >= 0) && (pp >= 0) && (p == (pp + 1) % 8);
      if (p < 0) begin
        e_oh    = 8'd0;
        e_idx   = 3'd0;
        e_legal = 1'b0;
        e_err   = 1'b1;
        m_state = 0;
      end else begin
        e_oh    = 8'd1 << p;
        e_idx   = 3'(p);
        e_legal = 1'b1;
        if (m_state == 0) begin
          m_state = 1;
          m_run   = 0;
        end else if (m_state == 1) begin
          if (ok) begin
            m_run++;
            if (m_run == LOCK_LEN) m_state = 2;
          end else begin
            e_err = 1'b1;
            m_run = 0;
          end
        end else begin
          if (ok) begin
            if (p == 0) e_done = 1'b1;
          end else begin
            e_err   = 1'b1;
            m_state = 1;
            m_run   = 0;
          end
        end
      end
      m_prev   = c;
      e_locked = (m_state == 2);
    end
    if (clr) begin
      e_errcnt = 0;
      e_cyc    = 0;
    end else begin
      if (e_err && e_errcnt < 255) e_errcnt++;
      if (e_done) e_cyc = (e_cyc + 1) % 65536;
    end
  endfunction

  task automatic drive(input logic v, input logic [3:0] c,
                       input logic clr);
    @(negedge clk);
    in_valid = v;
    jc_q     = c;
    clr_cnt  = clr;
    @(posedge clk);
    model_step(v, c, clr);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    jc_q     = 4'b0000;
    clr_cnt  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({phase_onehot, phase_idx, legal, locked, seq_err, cycle_done,
         err_cnt, cycle_cnt} !== 40'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got oh=%h idx=%0d lg=%b lk=%b err=%b dn=%b ec=%0d cc=%0d want all 0",
               phase_onehot, phase_idx, legal, locked, seq_err,
               cycle_done, err_cnt, cycle_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lock();
    logic [7:0] exp_oh;
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, code_of(k), 1'b0);
      exp_oh = 8'd1 << (k % 8);
      n_cmp++;
      if (phase_onehot !== exp_oh) begin
        n_bad++;
        $display("FAIL lock_onehot[%0d]: got %h want %h", k,
                 phase_onehot, exp_oh);
      end
      n_cmp++;
      if (seq_err !== 1'b0) begin
        n_bad++;
        $display("FAIL lock_seq_err[%0d]: got %b want 0", k, seq_err);
      end
      if (k == 7) begin
        n_cmp++;
        if (locked !== 1'b0) begin
          n_bad++;
          $display("FAIL lock_early: got %b want 0", locked);
        end
      end
    end
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++;
      $display("FAIL lock_acquired: got %b want 1", locked);
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 4'b0101, 1'b0);
    n_cmp++;
    if ({seq_err, legal, phase_onehot, locked, err_cnt} !==
        {1'b1, 1'b0, 8'd0, 1'b0, 8'd1}) begin
      n_bad++;
      $display("FAIL illegal_sample: got err=%b lg=%b oh=%h lk=%b ec=%0d want 1 0 00 0 1",
               seq_err, legal, phase_onehot, locked, err_cnt);
    end
    drive(1'b0, 4'b0101, 1'b0);
    n_cmp++;
    if (seq_err !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_pulse_width: got %b want 0", seq_err);
    end
    drive(1'b1, 4'b0000, 1'b0);
    n_cmp++;
    if ({seq_err, legal, phase_onehot, locked} !==
        {1'b0, 1'b1, 8'h01, 1'b0}) begin
      n_bad++;
      $display("FAIL illegal_recover: got err=%b lg=%b oh=%h lk=%b want 0 1 01 0",
               seq_err, legal, phase_onehot, locked);
    end
  endtask

  task automatic test_skip();
    for (int k = 1; k <= 15; k++) drive(1'b1, code_of(k), 1'b0);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++;
      $display("FAIL skip_prelock: got %b want 1", locked);
    end
    drive(1'b1, 4'b0000, 1'b0);
    drive(1'b1, 4'b1100, 1'b0);
    n_cmp++;
    if ({seq_err, locked, phase_idx} !== {1'b1, 1'b0, 3'd2}) begin
      n_bad++;
      $display("FAIL skip_detect: got err=%b lk=%b idx=%0d want 1 0 2",
               seq_err, locked, phase_idx);
    end
    for (int k = 3; k <= 10; k++) begin
      drive(1'b1, code_of(k), 1'b0);
      if (k == 9) begin
        n_cmp++;
        if (locked !== 1'b0) begin
          n_bad++;
          $display("FAIL skip_relock_early: got %b want 0", locked);
        end
      end
    end
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++;
      $display("FAIL skip_relock: got %b want 1", locked);
    end
  endtask

  task automatic test_repeat();
    drive(1'b1, 4'b1100, 1'b0);
    n_cmp++;
    if ({seq_err, legal, locked} !== 3'b110) begin
      n_bad++;
      $display("FAIL repeat_sample: got err=%b lg=%b lk=%b want 1 1 0",
               seq_err, legal, locked);
    end
  endtask

  task automatic test_laps();
    int n_done;
    bit bad_pos;
    for (int k = 3; k <= 10; k++) drive(1'b1, code_of(k), 1'b0);
    drive(1'b0, 4'b0000, 1'b1);
    n_cmp++;
    if ({locked, err_cnt, cycle_cnt} !== {1'b1, 8'd0, 16'd0}) begin
      n_bad++;
      $display("FAIL laps_clear: got lk=%b ec=%0d cc=%0d want 1 0 0",
               locked, err_cnt, cycle_cnt);
    end
    n_done  = 0;
    bad_pos = 0;
    for (int k = 11; k <= 34; k++) begin
      drive(1'b1, code_of(k), 1'b0);
      if (cycle_done) begin
        n_done++;
        if (code_of(k) != 4'b0000) bad_pos = 1;
      end
    end
    n_cmp++;
    if (n_done !== 3 || bad_pos) begin
      n_bad++;
      $display("FAIL laps_pulses: got %0d (misplaced=%0d) want 3 on 0000",
               n_done, bad_pos);
    end
    n_cmp++;
    if (cycle_cnt !== 16'd3) begin
      n_bad++;
      $display("FAIL laps_count: got %0d want 3", cycle_cnt);
    end
  endtask

  task automatic test_limits();
    for (int k = 0; k < 300; k++)
      drive(1'b1, (k % 2 == 0) ? 4'b0101 : 4'b1010, 1'b0);
    n_cmp++;
    if (err_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL err_saturate: got %0d want 255", err_cnt);
    end
    repeat (5) drive(1'b1, 4'b1001, 1'b0);
    n_cmp++;
    if (err_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL err_hold: got %0d want 255", err_cnt);
    end
    drive(1'b1, 4'b0101, 1'b1);
    n_cmp++;
    if ({seq_err, err_cnt} !== {1'b1, 8'd0}) begin
      n_bad++;
      $display("FAIL clr_vs_err: got err=%b ec=%0d want 1 0",
               seq_err, err_cnt);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k <= 8; k++) drive(1'b1, code_of(k), 1'b0);
    n_cmp++;
    if ({locked, phase_onehot} !== {1'b1, 8'h01}) begin
      n_bad++;
      $display("FAIL areset_prelock: got lk=%b oh=%h want 1 01",
               locked, phase_onehot);
    end
    @(negedge clk);
    in_valid = 1'b0;
    clk_en   = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if ({phase_onehot, phase_idx, legal, locked, seq_err, cycle_done,
         err_cnt, cycle_cnt} !== 40'd0) begin
      n_bad++;
      $display("FAIL areset_immediate: got oh=%h idx=%0d lg=%b lk=%b ec=%0d cc=%0d want all 0",
               phase_onehot, phase_idx, legal, locked, err_cnt,
               cycle_cnt);
    end
    #2;
    reset  = 1'b0;
    clk_en = 1'b1;
    drive(1'b1, 4'b1100, 1'b0);
    n_cmp++;
    if ({seq_err, legal, phase_idx} !== {1'b0, 1'b1, 3'd2}) begin
      n_bad++;
      $display("FAIL areset_first: got err=%b lg=%b idx=%0d want 0 1 2",
               seq_err, legal, phase_idx);
    end
  endtask

  task automatic test_random();
    int cur;
    int r;
    logic v;
    logic clr;
    logic [3:0] c;
    cur = 2;
    for (int i = 0; i < 800; i++) begin
      v   = ($urandom_range(0, 99) < 85);
      clr = ($urandom_range(0, 49) == 0);
      r   = $urandom_range(0, 99);
      if (r < 80)      c = code_of(cur + 1);
      else if (r < 87) c = code_of(cur);
      else if (r < 94) c = code_of($urandom_range(0, 7));
      else             c = 4'($urandom_range(0, 15));
      if (v && ph(c) >= 0) cur = ph(c);
      drive(v, c, clr);
      n_cmp++;
      if (phase_onehot !== e_oh) begin
        n_bad++;
        $display("FAIL rnd_onehot[%0d]: got %h want %h", i,
                 phase_onehot, e_oh);
      end
      n_cmp++;
      if (phase_idx !== e_idx) begin
        n_bad++;
        $display("FAIL rnd_idx[%0d]: got %0d want %0d", i,
                 phase_idx, e_idx);
      end
      n_cmp++;
      if (legal !== e_legal) begin
        n_bad++;
        $display("FAIL rnd_legal[%0d]: got %b want %b", i, legal, e_legal);
      end
      n_cmp++;
      if (locked !== e_locked) begin
        n_bad++;
        $display("FAIL rnd_locked[%0d]: got %b want %b", i,
                 locked, e_locked);
      end
      n_cmp++;
      if (seq_err !== e_err) begin
        n_bad++;
        $display("FAIL rnd_seq_err[%0d]: got %b want %b", i,
                 seq_err, e_err);
      end
      n_cmp++;
      if (cycle_done !== e_done) begin
        n_bad++;
        $display("FAIL rnd_cycle_done[%0d]: got %b want %b", i,
                 cycle_done, e_done);
      end
      n_cmp++;
      if (err_cnt !== 8'(e_errcnt)) begin
        n_bad++;
        $display("FAIL rnd_err_cnt[%0d]: got %0d want %0d", i,
                 err_cnt, e_errcnt);
      end
      n_cmp++;
      if (cycle_cnt !== 16'(e_cyc)) begin
        n_bad++;
        $display("FAIL rnd_cycle_cnt[%0d]: got %0d want %0d", i,
                 cycle_cnt, e_cyc);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    clk    = 1'b0;
    clk_en = 1'b1;
    test_reset();
    test_lock();
    test_illegal();
    test_skip();
    test_repeat();
    test_laps();
    test_limits();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
